// File: rtl/instr_imm_encoder.sv
// Packs opcode, register fields and a signed immediate into an RV32I word, range-checking the immediate.
// Latency: 2 cycles from input accept to out_valid; 1 word/cycle sustained throughput.
// Backpressure: each stage advances only when the next is empty or advancing; outputs held while !out_ready.
module instr_imm_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    // Word index within the DEPTH-word window; wraps the address back to BASE_ADDR.
    localparam int             IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Canonical NOP (addi x0, x0, 0) substituted for rejected words.
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Opcodes understood by the packer.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic    s1_valid;
    fields_t s1;

    logic    out_fire;
    logic    s2_load;
    logic    s1_move;
    logic    in_fire;

    assign out_fire = out_valid && out_ready;
    // Output register may take a new word when it is empty or being drained this cycle.
    assign s2_load  = !out_valid || out_ready;
    assign s1_move  = s1_valid && s2_load;
    assign in_ready = !s1_valid || s1_move;
    assign in_fire  = in_valid && in_ready;

    // Stage 1: capture raw fields on input handshake, empty when its word moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (in_fire) begin
            s1_valid    <= 1'b1;
            s1.opcode   <= in_opcode;
            s1.rd       <= in_rd;
            s1.rs1      <= in_rs1;
            s1.rs2      <= in_rs2;
            s1.funct3   <= in_funct3;
            s1.funct7   <= in_funct7;
            s1.imm      <= in_imm;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Range checks: the immediate is legal only if sign-extending the
    // field it is packed into reproduces the full 32-bit value.
    // ------------------------------------------------------------------
    logic [31:0] imm;
    logic        fits_i;
    logic        fits_b;
    logic        fits_u;
    logic        fits_j;

    assign imm    = s1.imm;
    assign fits_i = (imm == {{20{imm[11]}}, imm[11:0]});
    assign fits_b = (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
    assign fits_u = (imm[11:0] == 12'd0);
    assign fits_j = (imm == {{11{imm[20]}}, imm[20:0]}) && !imm[0];

    // ------------------------------------------------------------------
    // Bit scatter for each format
    // ------------------------------------------------------------------
    logic [31:0] word_i;
    logic [31:0] word_s;
    logic [31:0] word_b;
    logic [31:0] word_u;
    logic [31:0] word_j;
    logic [31:0] word_r;

    assign word_i = {imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
    assign word_s = {imm[11:5], s1.rs2, s1.rs1, s1.funct3, imm[4:0], s1.opcode};
    assign word_b = {imm[12], imm[10:5], s1.rs2, s1.rs1, s1.funct3,
                     imm[4:1], imm[11], s1.opcode};
    assign word_u = {imm[31:12], s1.rd, s1.opcode};
    assign word_j = {imm[20], imm[10:1], imm[11], imm[19:12], s1.rd, s1.opcode};
    assign word_r = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};

    logic [31:0] enc_word;
    logic        enc_ok;

    // Select the packed word and its legality from the stage-1 opcode.
    always_comb begin
        enc_word = NOP_WORD;
        enc_ok   = 1'b0;
        case (s1.opcode)
            OP_IMM, OP_LOAD: begin
                enc_word = word_i;
                enc_ok   = fits_i;
            end
            OP_STORE: begin
                enc_word = word_s;
                enc_ok   = fits_i;
            end
            OP_BRANCH: begin
                enc_word = word_b;
                enc_ok   = fits_b;
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = word_u;
                enc_ok   = fits_u;
            end
            OP_JAL: begin
                enc_word = word_j;
                enc_ok   = fits_j;
            end
            OP_REG: begin
                enc_word = word_r;
                enc_ok   = 1'b1;
            end
            default: begin
                enc_word = NOP_WORD;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // Stage 2: register the packed word (or NOP on rejection) and hold it until drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= enc_ok ? enc_word : NOP_WORD;
                out_err   <= !enc_ok;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address and error counters advance only on the output handshake,
    // so a stalled word keeps its address and is counted exactly once.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] word_idx;

    // Address walks by 4 bytes per emitted word and wraps after DEPTH words.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr <= BASE_ADDR;
            word_idx <= '0;
        end else if (out_fire) begin
            if (word_idx == LAST_IDX) begin
                out_addr <= BASE_ADDR;
                word_idx <= '0;
            end else begin
                out_addr <= out_addr + ADDR_W'(4);
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    // Saturating count of rejected words actually delivered downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (out_fire && out_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Scoreboard bench for instr_imm_encoder: directed spec cases plus randomized traffic under
// random backpressure, checked against a format-rule reference model.
module tb_instr_imm_encoder;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0080;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    instr_imm_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_opcode(in_opcode),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_funct3(in_funct3),
        .in_funct7(in_funct7),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_addr (out_addr),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;   // words delivered since reset
    int   n_err    = 0;   // error words delivered since reset
    int   bp_mode  = 0;   // 0: ready, 1: stalled, 2: random

    int         bnd [14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                             -1048576, -1048577, 1048574, 1048575, 1048576};
    logic [6:0] ops [8]  = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: legality from signed integer ranges, packing from the format tables.
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
        int          s;
        bit          ok;
        logic [31:0] w;
        s  = $signed(imm);
        ok = 1'b0;
        w  = 32'd0;
        case (op)
            7'h13, 7'h03: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = {imm[11:0], rs1, f3, rd, op};
            end
            7'h23: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            7'h63: begin
                ok = (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
                w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            7'h37, 7'h17: begin
                ok = ((imm % 32'd4096) == 32'd0);
                w  = {imm[31:12], rd, op};
            end
            7'h6F: begin
                ok = (s >= -1048576) && (s <= 1048574) && ((s % 2) == 0);
                w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            7'h33: begin
                ok = 1'b1;
                w  = {f7, rs2, rs1, f3, rd, op};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) return {1'b1, 32'h0000_0013};
        return {1'b0, w};
    endfunction

    // Present one word and wait (bounded) for acceptance; expectation queued on acceptance.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] e_instr, input logic e_err);
        exp_t e;
        bit   done;
        done      = 1'b0;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.instr = e_instr;
                e.err   = e_err;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after 500 cycles, required 1", in_ready);
        end
    endtask

    task automatic send_ref(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
        logic [32:0] r;
        r = ref_enc(op, rd, rs1, rs2, f3, f7, imm);
        send(op, rd, rs1, rs2, f3, f7, imm, r[31:0], r[32]);
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        n_out = 0;
        n_err = 0;
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_addr"},  out_addr,  BASE);
        chk({tag, "_err_cnt"},   err_cnt,   0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_out_err"},   out_err,   0);
        chk({tag, "_in_ready"},  in_ready,  1);
        rst = 1'b0;
    endtask

    // out_ready is owned here; changes land #2 after the edge, well clear of sampling.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = (bp_mode == 0) ? 1'b1 :
                        (bp_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stability while stalled, and scoreboard compare on every output handshake.
    initial begin
        logic        held_vld;
        logic [31:0] held_instr;
        logic [31:0] held_addr;
        logic        held_err;
        exp_t        e;
        held_vld = 1'b0;
        held_instr = '0;
        held_addr = '0;
        held_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_vld = 1'b0;
            end else begin
                if (held_vld) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_instr", out_instr, held_instr);
                    chk("hold_addr",  out_addr,  held_addr);
                    chk("hold_err",   out_err,   held_err);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: out_instr=%h delivered, required none", out_instr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_instr", out_instr, e.instr);
                        chk("out_err",   out_err,   e.err);
                        chk("out_addr",  out_addr,  BASE + 32'(4 * (n_out % DEPTH)));
                        chk("err_cnt",   err_cnt,   (n_err > 255) ? 255 : n_err);
                        n_out++;
                        if (e.err) n_err++;
                    end
                    held_vld = 1'b0;
                end else if (out_valid) begin
                    held_vld   = 1'b1;
                    held_instr = out_instr;
                    held_addr  = out_addr;
                    held_err   = out_err;
                end else begin
                    held_vld = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst_init");

        // Directed words with literal golden values, plus 2-cycle latency check.
        send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
        chk("lat_cycle1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_cycle2_addr",  out_addr,  BASE);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h0020_8463, 1'b0);
        send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
        drain();

        // Three rejected words: odd branch offset, out-of-range I immediate, unknown opcode.
        do_reset("rst_err");
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,    32'h0000_0013, 1'b1);
        send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
        send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,    32'h0000_0013, 1'b1);
        drain();
        chk("err_cnt_three", err_cnt, 3);

        // Five words through a DEPTH=4 window: last address wraps to BASE.
        do_reset("rst_wrap");
        for (int i = 0; i < 5; i++)
            send_ref(7'h33, 5'(i + 1), 5'd3, 5'd4, 3'd0, 7'h20, 32'd0);
        drain();
        chk("wrap_addr_after5", out_addr, BASE + 32'd4);

        // Backpressure: output stalled, pipeline fills, in_ready must fall and stay low.
        bp_mode = 1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_ref(7'h13, 5'(i), 5'd7, 5'd0, 3'd0, 7'd0, 32'(i * 100 - 200));
            end
            begin
                repeat (3) @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", in_ready, 0);
                end
                @(posedge clk);
                #1;
                bp_mode = 0;
            end
        join
        drain();

        // Randomized traffic under random output backpressure.
        bp_mode = 2;
        for (int i = 0; i < 200; i++) begin
            logic [6:0]  op;
            logic [31:0] imm;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 4))
                0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: imm = $urandom;
                2: imm = bnd[$urandom_range(0, 13)];
                3: imm = $urandom & 32'hFFFF_F000;
                default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
            endcase
            send_ref(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                     7'($urandom), imm);
        end
        drain();
        bp_mode = 0;

        // Reset with both stages full discards in-flight words.
        bp_mode = 1;
        @(posedge clk);
        #1;
        send_ref(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        send_ref(7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready",  in_ready,  0);
        do_reset("rst_mid");
        bp_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_valid", out_valid, 0);

        // 300 rejected words: counter saturates at 255.
        for (int i = 0; i < 300; i++)
            send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
        drain();
        chk("err_cnt_sat", err_cnt, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
